// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: responder side of the picorv32 native memory bus.
// Word-organised SRAM with byte-strobe writes and a programmable wait-state
// count. Also decodes a console byte register and a sticky test-pass flag.
// Optional feature: define MEM_RESP_RANDOM_STALL_EN to add 0..3 pseudo-random
// extra wait cycles per request. These come from a 16-bit Fibonacci LFSR.
module picorv32_mem_responder #(
   parameter int unsigned MEM_WORDS    = 32768,
   parameter int unsigned LATENCY      = 0,
   parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
   parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
   parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        console_valid,
   output logic [7:0]  console_data,
   output logic        tests_passed,
   output logic        bus_error
);

`ifdef MEM_RESP_RANDOM_STALL_EN
   localparam int unsigned CNT_W = 5;
`else
   localparam int unsigned CNT_W = 4;
`endif
   localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   if (LATENCY > 15) begin : g_latency_range
      $error("picorv32_mem_responder: LATENCY must be in 0..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [29:0]      word_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [31:0]      sram [0:MEM_WORDS-1];

   logic             accept;
   logic             ready_d;
   logic [31:0]      rdata_d;
   logic             cons_valid_d;
   logic [7:0]       cons_data_d;
   logic             passed_d;
   logic             error_d;
   logic             sram_we;
   logic [1:0]       stall;
   logic [AW-1:0]    widx;
   logic             hit_sram, hit_cons, hit_pass;
   logic             unused_addr_bits;

   // Byte offset within a word plays no part in decoding.
   assign unused_addr_bits = ^mem_addr[1:0];

   assign widx     = word_q[AW-1:0];
   assign hit_sram = (word_q < 30'(MEM_WORDS));
   assign hit_cons = (word_q == CONSOLE_ADDR[31:2]);
   assign hit_pass = (word_q == PASS_ADDR[31:2]);

`ifdef MEM_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   // Stall generator: steps once per accepted request.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr <= 16'hACE1;
      end else if (accept) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign stall = lfsr[1:0];
`else
   assign stall = '0;
`endif

   // Next-state, access decode and registered-output values.
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      accept       = 1'b0;
      ready_d      = 1'b0;
      rdata_d      = '0;
      cons_valid_d = 1'b0;
      cons_data_d  = console_data;
      passed_d     = tests_passed;
      error_d      = bus_error;
      sram_we      = 1'b0;
      case (state)
         IDLE: begin
            if (mem_valid) begin
               accept  = 1'b1;
               cnt_d   = CNT_W'(LATENCY) + CNT_W'(stall);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - 1'b1;
            end else begin
               ready_d = 1'b1;
               state_d = DONE;
               if (hit_sram) begin
                  if (wstrb_q == '0) rdata_d = sram[widx];
                  else               sram_we = 1'b1;
               end else if (hit_cons) begin
                  if (wstrb_q != '0) begin
                     cons_valid_d = 1'b1;
                     cons_data_d  = wdata_q[7:0];
                  end
               end else if (hit_pass) begin
                  if (wstrb_q != '0)
                     passed_d = (wstrb_q == 4'hF) && (wdata_q == PASS_MAGIC);
               end else begin
                  error_d = 1'b1;
                  if (wstrb_q == '0) rdata_d = 32'hDEAD_BEEF;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, request latch and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         cnt           <= '0;
         word_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         mem_ready     <= 1'b0;
         mem_rdata     <= '0;
         console_valid <= 1'b0;
         console_data  <= '0;
         tests_passed  <= 1'b0;
         bus_error     <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         mem_ready     <= ready_d;
         mem_rdata     <= rdata_d;
         console_valid <= cons_valid_d;
         console_data  <= cons_data_d;
         tests_passed  <= passed_d;
         bus_error     <= error_d;
         if (accept) begin
            word_q  <= mem_addr[31:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
         end
      end
   end

   // SRAM byte-lane writes; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (sram_we && wstrb_q[i])
            sram[widx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
   end

endmodule

// File: doc/picorv32_mem_responder.md
# picorv32_mem_responder

Responder (slave) side of the picorv32 native memory interface (`mem_valid`/`mem_ready`) for simulation benches and FPGA bring-up. It provides a word-organised SRAM with byte-strobe writes and a programmable wait-state count. It also decodes two MMIO registers: a console byte output and a test-pass flag. It connects directly to the core's `mem_*` ports, and `mem_rdata` feeds the core's read data input.

## Interface
- `MEM_WORDS`, 32768: SRAM depth in 32-bit words (128 KiB); array named `sram`, preloadable by `$readmemh`.
- `LATENCY`, 0: extra wait cycles per transaction, 0..15.
- `CONSOLE_ADDR`, 32'h1000_0000: console output register address.
- `PASS_ADDR`, 32'h2000_0000: test-pass register address.
- `PASS_MAGIC`, 32'd123456789: value that sets `tests_passed`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: request valid; held by the core until `mem_ready`.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 = read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, qualified by `mem_ready`.
- `console_valid` out 1: one-cycle pulse per console write.
- `console_data` out 8: console byte.
- `tests_passed` out 1: sticky pass flag.
- `bus_error` out 1: sticky flag for an out-of-range access.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - On `mem_valid`=1, latch addr/wdata/wstrb and load `cnt` = LATENCY (+ stall, see Configuration).
  - Then go to WAIT.
- **WAIT**
  - If `cnt` != 0: decrement and stay.
  - If `cnt` == 0: perform the access, register `mem_ready`=1 and `mem_rdata`, then go to DONE.
- **DONE**
  - `mem_ready` is high for this single cycle.
  - `mem_valid` is ignored; the core drops it at the end of this cycle.
  - Return to IDLE.
- **Address decode**, word index = addr[31:2]:
  - index < MEM_WORDS: SRAM.
  - addr == CONSOLE_ADDR: console register.
  - addr == PASS_ADDR: pass register.
  - Anything else: error.
- **SRAM write:** each byte lane i where wstrb[i]=1 is updated; other lanes unchanged.
- **SRAM read:** returns the full word.
- **Console write:** any nonzero wstrb pulses `console_valid` in the same cycle as `mem_ready`, with `console_data` = wdata[7:0].
- **Pass write:**
  - wstrb=4'hF and wdata==PASS_MAGIC sets `tests_passed`.
  - Any other write to the pass register clears it.
- **MMIO reads:** return 0.
- **Error access:**
  - Reads return 32'hDEAD_BEEF.
  - Writes are dropped.
  - `bus_error` is set and stays set until reset.
  - `mem_ready` still completes normally, so the core never hangs.
- `mem_rdata` = 0 whenever `mem_ready` = 0.
- **Reset values (all outputs 0):** `mem_ready`, `mem_rdata`, `console_valid`, `console_data`, `tests_passed`, `bus_error`. FSM = IDLE, `cnt` = 0.
- SRAM contents are not reset.

## Timing
- Request sampled at edge E0 (IDLE sees `mem_valid`): `mem_ready` is high in the cycle after edge E0+1+LATENCY. Total handshake = 2+LATENCY cycles from `mem_valid` rise to `mem_ready` high, inclusive of the valid cycle.
- The write takes effect on the edge that raises `mem_ready`. A read issued the very next transaction sees the new data.
- Back-to-back: the earliest new request is sampled one cycle after `mem_ready` drops (the DONE bubble). No request is ever double-accepted.
- Changes to `mem_addr`/`mem_wdata` during WAIT are ignored; latched values are used.
- `resetn` low in WAIT/DONE:
  - Immediately forces IDLE and `mem_ready`=0.
  - A pending write is discarded.
  - Sticky flags clear.
- `cnt` is 4 bits; LATENCY > 15 is a configuration error (elaboration-time check).

## Configuration
- `MEM_RESP_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances once per accepted request.
  - `cnt` loads LATENCY + lfsr[1:0], i.e. 0..3 extra cycles. `cnt` widens to 5 bits.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

## Test plan
- LATENCY=0, write 32'hCAFEBABE to 0x100 with wstrb=F, then read 0x100 -> `mem_ready` 2 cycles after valid; `mem_rdata`=32'hCAFEBABE.
- Byte strobes: preload 0x100=32'h11223344, write 32'hAABBCCDD with wstrb=4'b0101, read -> 32'h11BB33DD.
- LATENCY=3, read -> `mem_ready` exactly 5 cycles after valid rises, high for exactly 1 cycle; `mem_rdata`=0 in all other cycles.
- Write 32'h41 to 0x1000_0000 -> `console_valid` one-cycle pulse with `console_data`=8'h41. Then write 123456789 to 0x2000_0000 -> `tests_passed`=1. Then write 0 there -> 0.
- Read 0x3000_0000 -> `mem_rdata`=32'hDEADBEEF, `bus_error`=1 and stays 1. Assert `resetn`=0 mid-WAIT of the next write -> `mem_ready`=0, `bus_error`=0, target word unchanged.
- With `MEM_RESP_RANDOM_STALL_EN`, LATENCY=0, 1000 random transactions checked against a reference model -> all data correct; every handshake length is in 2..5 cycles.
